// File: rtl/uart_rx_byte_if.sv
// Serial line into the UART receiver and the byte stream it hands downstream.
interface uart_rx_byte_if;
  logic       rx;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_frame_err;

  modport master (input rx, output rx_valid, output rx_data, output rx_frame_err);
  modport slave  (output rx, input rx_valid, input rx_data, input rx_frame_err);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-cycle byte and
// framing-error strobes.
//
// state | meaning
// IDLE  | line high, waiting for a start edge
// START | counting to the middle of the start bit to reject glitches
// DATA  | sampling 8 data bits, LSB first
// STOP  | sampling the stop bit
// BREAK | stop bit was low; wait for the line to return high
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_byte_if.master rx_if
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  // Compares fire one cycle before the count "reaches" H / CLKS_PER_BIT
  // because the counter reads 0 on the first cycle of each state.
  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
  localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state, state_nxt;
  logic          rx_meta, rxs;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic [7:0]    shift, shift_nxt;
  logic [7:0]    data_q, data_nxt;
  logic          valid_q, valid_nxt;
  logic          err_q, err_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_if.rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_nxt;
      shift   <= shift_nxt;
      data_q  <= data_nxt;
      valid_q <= valid_nxt;
      err_q   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    data_nxt  = data_q;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rxs) state_nxt = START;
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_BIT) begin
          cnt_nxt   = '0;
          shift_nxt = {rxs, shift[7:1]};
          bit_nxt   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt == CNT_BIT) begin
          cnt_nxt = '0;
          // Leaving at mid-stop gives half a bit of slack for the next start edge.
          if (rxs) begin
            data_nxt  = shift;
            valid_nxt = 1'b1;
            state_nxt = IDLE;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_nxt = '0;
        if (rxs) state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign rx_if.rx_valid     = valid_q;
  assign rx_if.rx_data      = data_q;
  assign rx_if.rx_frame_err = err_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed and random frames for uart_rx_byte, checked against a frame-level
// timing/data model of the 8N1 receiver.
module tb_uart_rx_byte;

  localparam int CPB = 8;
  // Strobe is seen 2 (sync) + H + 9*CPB + 1 cycles after the pin edge.
  localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

  typedef struct packed {
    int unsigned cyc;
    logic [7:0]  data;
    logic        err;
  } ev_t;

  logic clk;
  logic rst;
  uart_rx_byte_if bus ();

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst   (rst),
    .rx_if (bus)
  );

  int unsigned cyc;
  int          n_checks;
  int          n_err;
  int          both_cnt;
  logic [7:0]  last_good;
  ev_t         obs_q[$];
  ev_t         exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rx_valid && bus.rx_frame_err) both_cnt++;
    if (bus.rx_valid)     obs_q.push_back('{cyc: cyc, data: bus.rx_data, err: 1'b0});
    if (bus.rx_frame_err) obs_q.push_back('{cyc: cyc, data: bus.rx_data, err: 1'b1});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    bus.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; drives one full frame and records what the receiver must report.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    if (stop) begin
      exp_q.push_back('{cyc: cyc + LAT, data: d, err: 1'b0});
      last_good = d;
    end else begin
      exp_q.push_back('{cyc: cyc + LAT, data: last_good, err: 1'b1});
    end
    for (int i = 0; i < 10; i++) begin
      bus.rx = bits[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic compare_events(input string tag);
    int n;
    repeat (4) @(negedge clk);
    chk({tag, " strobe count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s[%0d] cycle", tag, i), obs_q[i].cyc,  exp_q[i].cyc);
      chk($sformatf("%s[%0d] data", tag, i),  obs_q[i].data, exp_q[i].data);
      chk($sformatf("%s[%0d] kind", tag, i),  obs_q[i].err,  exp_q[i].err);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    n_checks  = 0;
    n_err     = 0;
    both_cnt  = 0;
    last_good = 8'h00;
    rst       = 1'b0;
    bus.rx    = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset rx_valid", bus.rx_valid, 1'b0);
    chk("reset rx_frame_err", bus.rx_frame_err, 1'b0);
    chk("reset rx_data", bus.rx_data, 8'h00);
    rst = 1'b1;
    idle_cycles(10);

    // Single byte, latency checked through the model's expected cycle.
    send_frame(8'h61, 1'b1);
    compare_events("byte61");
    chk("rx_data holds 61", bus.rx_data, 8'h61);

    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'hA5, 1'b1);
    compare_events("b2b");

    // Start-bit glitch must be rejected, receiver then takes a real frame.
    bus.rx = 1'b0;
    repeat (2) @(negedge clk);
    idle_cycles(20);
    compare_events("glitch");
    send_frame(8'h3C, 1'b1);
    compare_events("after glitch");

    // Bad stop bit followed by a long break.
    send_frame(8'h55, 1'b0);
    repeat (200) @(negedge clk);
    compare_events("break");
    chk("rx_data kept in break", bus.rx_data, 8'h3C);
    idle_cycles(12);
    send_frame(8'h7E, 1'b1);
    compare_events("after break");

    // Asynchronous reset in the middle of data bit 3 of 0xC3.
    bus.rx = 1'b0; repeat (CPB) @(negedge clk);
    bus.rx = 1'b1; repeat (CPB) @(negedge clk);
    bus.rx = 1'b1; repeat (CPB) @(negedge clk);
    bus.rx = 1'b0; repeat (CPB) @(negedge clk);
    bus.rx = 1'b0; repeat (3) @(negedge clk);
    #3;
    rst    = 1'b0;
    bus.rx = 1'b1;
    #1;
    chk("midreset rx_valid", bus.rx_valid, 1'b0);
    chk("midreset rx_frame_err", bus.rx_frame_err, 1'b0);
    chk("midreset rx_data", bus.rx_data, 8'h00);
    #27;
    rst = 1'b1;
    last_good = 8'h00;
    @(negedge clk);
    idle_cycles(100);
    compare_events("aborted frame");
    chk("rx_data after reset", bus.rx_data, 8'h00);
    send_frame(8'h42, 1'b1);
    compare_events("after reset");

    // Random bytes with random idle gaps, including zero-gap back-to-back.
    for (int k = 0; k < 20; k++) begin
      idle_cycles($urandom_range(0, 12));
      send_frame(8'($urandom), 1'b1);
    end
    compare_events("random");

    chk("strobes never together", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
UART receiver that sits directly upstream of the puzzle logic. It turns the asynchronous serial line from the host into a stream of bytes, using the valid/data pair that the puzzle stage consumes. The frame format is fixed 8N1: 1 start bit, 8 data bits LSB first, no parity, 1 stop bit. Each good byte is reported by a single-cycle strobe; a bad stop bit is reported on a separate error strobe.

Parameters:
CLKS_PER_BIT, 104, clk cycles per bit period (12 MHz / 115200); must be >= 4; H = CLKS_PER_BIT/2, rounded down.

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  reset; asynchronous, active-low (rst=0 resets)
rx  input  1  serial line, asynchronous to clk; idles high
rx_valid  output  1  one-cycle strobe, rx_data holds a new good byte
rx_data  output  8  last good byte received; stable between strobes
rx_frame_err  output  1  one-cycle strobe, the stop bit sampled 0

Behaviour:
- Reset values (rst=0, async): rx_valid=0, rx_frame_err=0, rx_data=8'h00; state=IDLE; counters=0; shift register=0; both synchroniser flops=1.
- Synchroniser: rx passes through 2 flops. rxs (the second flop) is the only version of the line the FSM uses.
- Bit counter: counts 0..7. Cycle counter: width $clog2(CLKS_PER_BIT), cleared on every state entry.
- Define t0 as the first cycle in IDLE where rxs=0. Sample points:
  - start bit at t0+H
  - data bit i (i=0..7) at t0+H+(i+1)*CLKS_PER_BIT
  - stop bit at t0+H+9*CLKS_PER_BIT
- IDLE:
  - rxs=0 -> START.
- START:
  - Waits until the cycle counter reaches H.
  - rxs=0 -> DATA; rxs=1 -> IDLE (glitch; no outputs).
- DATA:
  - Samples every CLKS_PER_BIT cycles.
  - Shifts right with the new bit into [7]; the first bit received ends in [0].
  - After the 8th sample -> STOP.
- STOP, after CLKS_PER_BIT cycles:
  - rxs=1: rx_data <= shift register; rx_valid=1 in the following cycle; -> IDLE.
  - rxs=0: rx_frame_err=1 in the following cycle; rx_data unchanged; no rx_valid; -> BREAK.
- BREAK:
  - Waits for rxs=1, then -> IDLE.
  - Prevents a held-low line (break) from being decoded as a stream of 0x00 frames.
- Strobes: rx_valid and rx_frame_err are exactly 1 cycle wide and never high together.
- Latency: rx_valid rises at t0+H+9*CLKS_PER_BIT+1. The rx pin leads t0 by the 2-cycle synchroniser delay.
- Back-to-back frames: IDLE is re-entered half a bit before the stop bit ends. A start edge arriving right after the stop bit is caught with no frame lost.
- The block has no backpressure. The consumer must take each byte on its rx_valid; the next byte overwrites rx_data no sooner than 10 bit periods later.
- Reset mid-frame: all state is dropped immediately. After rst returns to 1 the block waits in IDLE for a fresh falling edge; a partial frame never produces a strobe.
- rx high throughout: stays in IDLE, no strobes.

Test Plan (CLKS_PER_BIT=8, H=4; bit period = 8 clk):
- Send 0x61 ('a') -> one rx_valid pulse; rx_data=0x61; rx_valid rises exactly 77 cycles after the first synced low (+2 cycles from the pin); rx_frame_err stays 0.
- Send 0x00, 0xFF, 0xA5 back-to-back, each with one stop bit and no idle gap -> three rx_valid pulses, rx_data = 0x00, 0xFF, 0xA5 in that order, pulses 80 cycles apart.
- Drive rx low for 2 clk, then high -> no strobes, FSM back in IDLE; a following 0x3C frame is received as 0x3C.
- Send 0x55 with the stop bit forced 0, then hold rx low for 200 clk -> exactly one rx_frame_err pulse; no rx_valid; rx_data keeps its previous value. Then release high and send 0x7E -> rx_valid with 0x7E.
- Assert rst=0 for 3 cycles during data bit 3 of a 0xC3 frame, asynchronously with respect to clk -> all outputs 0 immediately, rx_data=0x00; no strobe for the aborted frame. After release, send 0x42 -> rx_valid with 0x42.
